// File: rtl/seq_monitor_pkg.sv
// seq_monitor_pkg: sequence constants and state encoding shared by the monitor.
package seq_monitor_pkg;
  localparam logic [3:0] START = 4'd13;
  localparam logic [3:0] END = 4'd3;
  localparam logic [3:0] STEP = 4'd2;
  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'b00;
  localparam state_t HUNT = 2'b01;
  localparam state_t TRACK = 2'b10;
endpackage

// File: rtl/seq_monitor_if.sv
// seq_monitor_if: sample stream in, lock/error status out.
interface seq_monitor_if #(parameter int CNT_W = 8);
  logic en;
  logic in_valid;
  logic [3:0] in_data;
  logic locked;
  logic err;
  logic [1:0] state;
  logic [CNT_W-1:0] period_cnt;
  logic [CNT_W-1:0] err_cnt;
  modport master (output en, in_valid, in_data, input locked, err, state, period_cnt, err_cnt);
  modport slave (input en, in_valid, in_data, output locked, err, state, period_cnt, err_cnt);
endinterface

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear.
module sat_counter #(parameter int W = 8) (
  input logic clk,
  input logic rst,
  input logic clr,
  input logic inc,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else cnt <= clr ? '0 : (inc && !(&cnt)) ? cnt + 1'b1 : cnt;
endmodule

// File: rtl/seq_monitor.sv
// seq_monitor: tracks the 13,11,...,3 sequence; SEQ_MONITOR_ERRCNT_EN adds the error counter.
module seq_monitor
  import seq_monitor_pkg::*;
#(parameter int CNT_W = 8) (
  input logic clk,
  input logic rst,
  seq_monitor_if.slave bus
);
  state_t state_q, state_d;
  logic [3:0] exp_q, exp_d;
  logic err_q, err_d, period_inc;
  logic [CNT_W-1:0] period_cnt, err_cnt;
  always_comb begin
    state_d = state_q;
    exp_d = exp_q;
    err_d = 1'b0;
    period_inc = 1'b0;
    if (!bus.en) begin
      state_d = IDLE;
      exp_d = START;
    end else case (state_q)
      IDLE: state_d = HUNT;
      HUNT: if (bus.in_valid && bus.in_data == START) begin
        state_d = TRACK;
        exp_d = START - STEP;
      end
      TRACK: if (bus.in_valid) begin
        if (bus.in_data == exp_q) begin
          period_inc = exp_q == END;
          exp_d = (exp_q == END) ? START : exp_q - STEP;
        end else begin
          err_d = 1'b1;
          // a fresh START during a mismatch is taken as the beginning of a new period
          state_d = (bus.in_data == START) ? TRACK : HUNT;
          exp_d = (bus.in_data == START) ? START - STEP : START;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      exp_q <= START;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      exp_q <= exp_d;
      err_q <= err_d;
    end
  sat_counter #(.W(CNT_W)) u_period (.clk(clk), .rst(rst), .clr(1'b0), .inc(period_inc), .cnt(period_cnt));
`ifdef SEQ_MONITOR_ERRCNT_EN
  sat_counter #(.W(CNT_W)) u_err (.clk(clk), .rst(rst), .clr(1'b0), .inc(err_d), .cnt(err_cnt));
`else
  assign err_cnt = '0;
`endif
  assign bus.state = state_q;
  assign bus.locked = state_q == TRACK;
  assign bus.err = err_q;
  assign bus.period_cnt = period_cnt;
  assign bus.err_cnt = err_cnt;
endmodule

// File: tb/tb_seq_monitor.sv
// tb_seq_monitor: scoreboard bench driving an 8-bit and a 2-bit counter instance in lockstep.
module tb_seq_monitor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  seq_monitor_if #(.CNT_W(8)) bus8 ();
  seq_monitor_if #(.CNT_W(2)) bus2 ();
  seq_monitor #(.CNT_W(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));
  seq_monitor #(.CNT_W(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));
  typedef struct {
    logic [1:0] st;
    logic lk;
    logic er;
    logic [7:0] pc;
    logic [7:0] ec;
    logic [1:0] pc2;
  } exp_t;
  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;
  logic [1:0] m_st;
  logic [3:0] m_exp;
  logic m_er;
  logic [7:0] m_pc, m_ec;
  logic [1:0] m_pc2;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask
  task automatic model_reset();
    m_st = 2'b00; m_exp = 4'd13; m_er = 1'b0; m_pc = 8'd0; m_ec = 8'd0; m_pc2 = 2'd0;
  endtask
  task automatic model_step(input logic v, input logic [3:0] d, input logic e);
    m_er = 1'b0;
    if (!e) begin
      m_st = 2'b00; m_exp = 4'd13;
    end else if (m_st == 2'b00) m_st = 2'b01;
    else if (m_st == 2'b01) begin
      if (v && d == 4'd13) begin m_st = 2'b10; m_exp = 4'd11; end
    end else if (v) begin
      if (d == m_exp) begin
        if (m_exp == 4'd3) begin
          m_exp = 4'd13;
          if (m_pc != 8'hff) m_pc++;
          if (m_pc2 != 2'd3) m_pc2++;
        end else m_exp = m_exp - 4'd2;
      end else begin
        m_er = 1'b1;
`ifdef SEQ_MONITOR_ERRCNT_EN
        if (m_ec != 8'hff) m_ec++;
`endif
        if (d == 4'd13) m_exp = 4'd11;
        else begin m_st = 2'b01; m_exp = 4'd13; end
      end
    end
  endtask
  task automatic cycle(input logic v, input logic [3:0] d, input logic e);
    exp_t x;
    @(negedge clk);
    bus8.in_valid = v; bus8.in_data = d; bus8.en = e;
    bus2.in_valid = v; bus2.in_data = d; bus2.en = e;
    model_step(v, d, e);
    sb.push_back('{st: m_st, lk: m_st == 2'b10, er: m_er, pc: m_pc, ec: m_ec, pc2: m_pc2});
    @(posedge clk);
    #1;
    x = sb.pop_front();
    chk("state", 32'(bus8.state), 32'(x.st));
    chk("locked", 32'(bus8.locked), 32'(x.lk));
    chk("err", 32'(bus8.err), 32'(x.er));
    chk("period_cnt", 32'(bus8.period_cnt), 32'(x.pc));
    chk("err_cnt", 32'(bus8.err_cnt), 32'(x.ec));
    chk("period_cnt_w2", 32'(bus2.period_cnt), 32'(x.pc2));
    chk("state_w2", 32'(bus2.state), 32'(x.st));
  endtask
  task automatic feed_period();
    for (int k = 13; k >= 3; k -= 2) cycle(1'b1, 4'(k), 1'b1);
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_state"}, 32'(bus8.state), 32'd0);
    chk({tag, "_locked"}, 32'(bus8.locked), 32'd0);
    chk({tag, "_err"}, 32'(bus8.err), 32'd0);
    chk({tag, "_period"}, 32'(bus8.period_cnt), 32'd0);
    chk({tag, "_errcnt"}, 32'(bus8.err_cnt), 32'd0);
    chk({tag, "_period_w2"}, 32'(bus2.period_cnt), 32'd0);
  endtask
  initial begin
    bus8.en = 1'b0; bus8.in_valid = 1'b0; bus8.in_data = 4'd0;
    bus2.en = 1'b0; bus2.in_valid = 1'b0; bus2.in_data = 4'd0;
    model_reset();
    #12;
    chk_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    cycle(1'b1, 4'd13, 1'b1);
    chk("idle_ignores_valid", 32'(bus8.state), 32'd1);
    for (int p = 0; p < 3; p++) feed_period();
    chk("three_periods", 32'(bus8.period_cnt), 32'd3);
    cycle(1'b1, 4'd13, 1'b1);
    cycle(1'b1, 4'd11, 1'b1);
    cycle(1'b1, 4'd8, 1'b1);
    chk("bad_to_hunt", 32'(bus8.state), 32'd1);
    cycle(1'b0, 4'd0, 1'b1);
    chk("err_one_cycle", 32'(bus8.err), 32'd0);
    cycle(1'b1, 4'd13, 1'b1);
    cycle(1'b1, 4'd11, 1'b1);
    cycle(1'b1, 4'd9, 1'b1);
    cycle(1'b1, 4'd13, 1'b1);
    chk("resync_track", 32'(bus8.state), 32'd2);
    cycle(1'b1, 4'd11, 1'b1);
    cycle(1'b0, 4'd5, 1'b1);
    cycle(1'b0, 4'd5, 1'b1);
    cycle(1'b1, 4'd9, 1'b1);
    cycle(1'b1, 4'd7, 1'b0);
    chk("en_low_idle", 32'(bus8.state), 32'd0);
    cycle(1'b0, 4'd0, 1'b1);
    cycle(1'b1, 4'd13, 1'b1);
    cycle(1'b1, 4'd11, 1'b1);
    cycle(1'b1, 4'd9, 1'b1);
    cycle(1'b1, 4'd7, 1'b1);
    cycle(1'b1, 4'd5, 1'b1);
    cycle(1'b1, 4'd3, 1'b1);
    feed_period();
    chk("five_periods", 32'(bus8.period_cnt), 32'd5);
    chk("sat_w2", 32'(bus2.period_cnt), 32'd3);
    for (int i = 0; i < 8; i++) cycle(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'b1);
    cycle(1'b1, 4'd13, 1'b1);
    cycle(1'b1, 4'd11, 1'b1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 chk_zero("async_rst");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    cycle(1'b0, 4'd0, 1'b1);
    cycle(1'b1, 4'd7, 1'b1);
    cycle(1'b1, 4'd5, 1'b1);
    cycle(1'b1, 4'd3, 1'b1);
    chk("restart_hunt", 32'(bus8.state), 32'd1);
    feed_period();
    chk("post_rst_period", 32'(bus8.period_cnt), 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/seq_monitor.md
SEQ_MONITOR -- requirements
Module: seq_monitor

Interface
REQ-001 Parameter CNT_W, default 8: width of the period and error counters.
REQ-002 Clock is `clk`; reset is `rst`, asynchronous, active-high; single clock domain.
REQ-003 clk  input  1  rising-edge system clock.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 en  input  1  monitor enable; low forces IDLE.
REQ-006 in_valid  input  1  one-cycle strobe, in_data is a new generator sample.
REQ-007 in_data  input  4  sample from the upstream sequence generator.
REQ-008 locked  output  1  high while in TRACK.
REQ-009 err  output  1  one-cycle pulse on a sequence mismatch.
REQ-010 state  output  2  IDLE=00, HUNT=01, TRACK=10 (11 unused).
REQ-011 period_cnt  output  CNT_W  complete periods seen, saturating.
REQ-012 err_cnt  output  CNT_W  mismatches seen, saturating (see Configuration).

Function
REQ-013 The expected sequence SHALL be 13, 11, 9, 7, 5, 3, repeating: START=13, END=3, STEP=2.
REQ-014 All outputs SHALL be registered; a sample's effect is visible the cycle after its in_valid.
REQ-015 The block SHALL hold an internal 4-bit expected value exp.
REQ-016 IDLE: if en=1, go to HUNT next cycle; in_valid ignored in IDLE.
REQ-017 HUNT: in_valid with in_data=START -> TRACK, exp=11; any other sample -> stay HUNT, no err.
REQ-018 TRACK match (in_data=exp): if exp=END, then exp=START and period_cnt+1; else exp=exp-2.
REQ-019 TRACK mismatch: err pulses for 1 cycle.
REQ-020 On a TRACK mismatch with in_data=START, the block SHALL stay in TRACK with exp=11 (resync).
REQ-021 On a TRACK mismatch with any other in_data, the block SHALL go to HUNT with exp=START.
REQ-022 en=0 in any state SHALL move to IDLE next cycle, ignore same-cycle in_valid, and hold both counters.
REQ-023 Counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-024 Cycles without in_valid SHALL leave state, exp and counters unchanged.
REQ-025 locked SHALL equal (state==TRACK) and deassert the cycle after a non-resync mismatch.

Reset
REQ-026 rst=1 SHALL asynchronously force state=IDLE, exp=START, locked=0, err=0, period_cnt=0, err_cnt=0.
REQ-027 Reset release mid-sequence SHALL restart hunting; no err is raised for the partial period.

Configuration
REQ-028 Macro SEQ_MONITOR_ERRCNT_EN defined: err_cnt SHALL increment, saturating, on every err pulse.
REQ-029 Macro SEQ_MONITOR_ERRCNT_EN undefined: err_cnt SHALL be tied to 0 with no counter register; err behaves the same.

Structure
REQ-030 Package seq_monitor_pkg SHALL hold START, END and STEP constants and the state encoding type.
REQ-031 One sub-module, sat_counter (parameterised width, inc, clear, saturate), SHALL implement both counters.

Verification
REQ-032 Reset, en=1, feed 13,11,9,7,5,3 ×3 -> locked from 2nd cycle after 13, period_cnt=3, err never pulses.
REQ-033 Locked, feed 13,11,8 -> err pulses once, state=HUNT, locked=0, err_cnt=1 (macro on) / 0 (macro off).
REQ-034 Locked at exp=7, feed 13 -> err pulses, state stays TRACK, next 11 accepted without err.
REQ-035 CNT_W=2, feed 5 full periods -> period_cnt saturates at 3.
REQ-036 en=0 together with in_valid=1 in TRACK -> IDLE next cycle, counters hold, no err.
REQ-037 rst asserted mid-period, between clock edges -> outputs zero immediately, state=IDLE before the next edge.
